// File: rtl/pc_fetch_if.sv
// Instruction-memory req/ack port of the fetch stage.
// The master (fetch stage) holds the address stable until the single-cycle ack.
interface pc_fetch_if;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_ack_i;
    logic [31:0] inst_rdata_i;

    modport master (
        output inst_req_o,
        output inst_addr_o,
        input  inst_ack_i,
        input  inst_rdata_i
    );

    modport slave (
        input  inst_req_o,
        input  inst_addr_o,
        output inst_ack_i,
        output inst_rdata_i
    );
endinterface

// File: rtl/pc_fetch.sv
// Fetch stage feeding IF/ID: PC, req/ack memory port, branch/flush redirect.
// Optional FETCH_TIMEOUT_EN adds an ack-wait watchdog that fakes a zero-word ack.
module pc_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    pc_fetch_if.master  imem,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if,
    output logic        if_fetch_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN
    } state_e;

    state_e      st_q, st_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] drn_q, drn_d;
    logic [31:0] bpc_q, bpc_d;
    logic [31:0] binst_q, binst_d;
    logic        pend_q, pend_d;
    logic        berr_q, berr_d;

    logic        stop;
    logic        ack;
    logic        tmo;
    logic        latch;
    logic [31:0] rdata;
    logic [31:0] npc;
    logic [31:0] flush_pc;
    logic [31:0] br_pc;
    logic        unused_stall;

    assign stop         = stall[1];
    assign unused_stall = ^{stall[5:2], stall[0]};
    assign flush_pc     = {new_pc[31:2], 2'b00};
    assign br_pc        = {branch_target_i[31:2], 2'b00};
    assign latch        = branch_flag_i && !pend_q;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       wait_st;

    assign wait_st = (st_q == REQ) || (st_q == DRAIN);
    assign tmo     = wait_st && !imem.inst_ack_i &&
                     (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    assign cnt_d   = (wait_st && !imem.inst_ack_i && !tmo) ?
                     cnt_q + 8'd1 : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end
`else
    logic unused_tmo;

    assign tmo        = 1'b0;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

    // A timeout behaves like an ack carrying a zero word.
    assign ack   = imem.inst_ack_i || tmo;
    assign rdata = imem.inst_ack_i ? imem.inst_rdata_i : 32'h0;

    always_comb begin
        if (flush)       npc = flush_pc;
        else if (pend_q) npc = tgt_q;
        else if (branch_flag_i) npc = br_pc;
        else             npc = pc_q + 32'd4;
    end

    always_comb begin
        st_d    = st_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        tgt_d   = tgt_q;
        drn_d   = drn_q;
        bpc_d   = bpc_q;
        binst_d = binst_q;
        berr_d  = berr_q;
        unique case (st_q)
            IDLE: begin
                st_d = REQ;
                if (flush) pc_d = flush_pc;
            end
            REQ: begin
                if (flush) begin
                    pc_d   = flush_pc;
                    pend_d = 1'b0;
                    if (!ack) begin
                        drn_d = pc_q;
                        st_d  = DRAIN;
                    end
                end else if (ack && !stop) begin
                    pc_d   = npc;
                    pend_d = 1'b0;
                end else begin
                    if (ack) begin
                        bpc_d   = pc_q;
                        binst_d = rdata;
                        berr_d  = tmo;
                        st_d    = HOLD;
                    end
                    if (latch) begin
                        pend_d = 1'b1;
                        tgt_d  = br_pc;
                    end
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_d   = flush_pc;
                    pend_d = 1'b0;
                    st_d   = REQ;
                end else if (!stop) begin
                    pc_d   = npc;
                    pend_d = 1'b0;
                    st_d   = REQ;
                end else if (latch) begin
                    pend_d = 1'b1;
                    tgt_d  = br_pc;
                end
            end
            DRAIN: begin
                // Keep the old request on the bus; only the PC moves.
                if (flush) begin
                    pc_d   = flush_pc;
                    pend_d = 1'b0;
                end
                if (ack) st_d = REQ;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= 1'b0;
            tgt_q   <= 32'h0;
            drn_q   <= 32'h0;
            bpc_q   <= 32'h0;
            binst_q <= 32'h0;
            berr_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
            drn_q   <= drn_d;
            bpc_q   <= bpc_d;
            binst_q <= binst_d;
            berr_q  <= berr_d;
        end
    end

    always_comb begin
        imem.inst_req_o  = 1'b0;
        imem.inst_addr_o = 32'h0;
        if_pc            = 32'h0;
        if_inst          = 32'h0;
        stallreq_if      = 1'b0;
        if_fetch_err_o   = 1'b0;
        if (!rst) begin
            unique case (st_q)
                IDLE: ;
                REQ: begin
                    imem.inst_req_o  = 1'b1;
                    imem.inst_addr_o = pc_q;
                    stallreq_if      = !ack;
                    if (ack && !flush) begin
                        if_pc          = pc_q;
                        if_inst        = rdata;
                        if_fetch_err_o = tmo;
                    end
                end
                HOLD: begin
                    if (!flush) begin
                        if_pc          = bpc_q;
                        if_inst        = binst_q;
                        if_fetch_err_o = berr_q;
                    end
                end
                DRAIN: begin
                    imem.inst_req_o  = 1'b1;
                    imem.inst_addr_o = drn_q;
                    stallreq_if      = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: random-wait memory, random stall/branch/flush,
// checked against an instruction-stream model of the fetch rules.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;
    logic        if_fetch_err_o;

    always #5 clk = ~clk;

    pc_fetch_if imem ();

    pc_fetch #(
        .RESET_PC       (32'h0000_0000),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .new_pc          (new_pc),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .imem            (imem),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .stallreq_if     (stallreq_if),
        .if_fetch_err_o  (if_fetch_err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memf(logic [31:0] a);
        return ((a * 32'h9E37_79B1) ^ 32'h5A5A_0000) | 32'h1;
    endfunction

    function automatic logic [31:0] rnd_pc();
        if ($urandom_range(0, 3) == 0)
            return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        return $urandom & 32'h0000_3FFF;
    endfunction

    logic [31:0] exp_pc, tgt, prev_addr;
    bit  pend, have_w, drain, busy, prev_req, prev_ack, dead;
    int  wl, idle_n;
    int  min_w, max_w, p_stall, p_br, p_fl;

    task automatic model_reset();
        exp_pc   = 32'h0;
        tgt      = 32'h0;
        pend     = 1'b0;
        have_w   = 1'b0;
        drain    = 1'b0;
        busy     = 1'b0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        idle_n   = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst                = 1'b1;
        stall              = '0;
        flush              = 1'b0;
        new_pc             = '0;
        branch_flag_i      = 1'b0;
        branch_target_i    = '0;
        imem.inst_ack_i    = 1'b0;
        imem.inst_rdata_i  = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", 32'(imem.inst_req_o), 0);
        check("rst_addr", imem.inst_addr_o, 0);
        check("rst_pc", if_pc, 0);
        check("rst_inst", if_inst, 0);
        check("rst_sreq", 32'(stallreq_if), 0);
        check("rst_err", 32'(if_fetch_err_o), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_req", 32'(imem.inst_req_o), 0);
        check("idle_pc", if_pc, 0);
        check("idle_inst", if_inst, 0);
        check("idle_sreq", 32'(stallreq_if), 0);
        model_reset();
    endtask

    task automatic cycle();
        logic        req, ack, pres, cons, stp;
        logic [31:0] addr;
        @(negedge clk);
        stall    = 6'($urandom);
        stall[1] = ($urandom_range(0, 99) < p_stall);
        flush    = ($urandom_range(0, 99) < p_fl);
        new_pc   = rnd_pc();
        branch_flag_i   = !flush && !drain && !pend &&
                          ($urandom_range(0, 99) < p_br);
        branch_target_i = rnd_pc();
        req  = imem.inst_req_o;
        addr = imem.inst_addr_o;
        if (req && !busy) begin
            busy = 1'b1;
            wl   = $urandom_range(min_w, max_w);
        end
        ack = req && busy && (wl == 0);
        imem.inst_ack_i   = ack;
        imem.inst_rdata_i = ack ? memf(addr) : $urandom;
        #1;
        stp  = stall[1];
        pres = !flush && ((ack && !drain) || have_w);
        if (prev_req && !prev_ack) begin
            check("req_hold", 32'(req), 1);
            check("addr_hold", addr, prev_addr);
        end
        check("if_inst", if_inst, pres ? memf(exp_pc) : 32'h0);
        check("if_pc", if_pc, pres ? exp_pc : 32'h0);
        if (ack && !drain && !flush) check("fetch_addr", addr, exp_pc);
        if (req && !ack) check("sreq_wait", 32'(stallreq_if), 1);
        if (pres) check("sreq_pres", 32'(stallreq_if), 0);
        if (have_w) check("hold_noreq", 32'(req), 0);
        check("err", 32'(if_fetch_err_o), 0);
        cons = pres && !stp;
        if (flush) begin
            exp_pc = new_pc & ~32'h3;
            pend   = 1'b0;
            have_w = 1'b0;
            drain  = req && !ack;
        end else if (drain) begin
            if (ack) drain = 1'b0;
        end else if (cons) begin
            if (pend)               exp_pc = tgt;
            else if (branch_flag_i) exp_pc = branch_target_i & ~32'h3;
            else                    exp_pc = exp_pc + 32'd4;
            pend   = 1'b0;
            have_w = 1'b0;
        end else begin
            if (ack) have_w = 1'b1;
            if (branch_flag_i && !pend) begin
                pend = 1'b1;
                tgt  = branch_target_i & ~32'h3;
            end
        end
        if (flush || cons) idle_n = 0;
        else               idle_n++;
        if (idle_n > 100 && !dead) begin
            dead = 1'b1;
            check("liveness", 32'(idle_n), 0);
        end
        if (ack)              busy = 1'b0;
        else if (req && busy) wl--;
        prev_req  = req;
        prev_ack  = ack;
        prev_addr = addr;
    endtask

    initial begin
        int n;
`ifdef FETCH_TIMEOUT_EN
        int n8;
        bit seen, done;
`endif
        rst  = 1'b1;
        dead = 1'b0;
        do_reset();

        min_w = 0; max_w = 0; p_stall = 0; p_br = 0; p_fl = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("t1_addr", imem.inst_addr_o, 32'(4 * k));
            check("t1_ack", 32'(imem.inst_ack_i), 1);
            check("t1_sreq", 32'(stallreq_if), 0);
        end

        min_w = 3; max_w = 3; n = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (imem.inst_ack_i) break;
            n += int'(stallreq_if);
        end
        check("t2_waits", 32'(n), 3);

        min_w = 0; max_w = 0; p_stall = 100;
        repeat (5) cycle();
        p_stall = 0;
        repeat (3) cycle();

        min_w = 0; max_w = 3; p_stall = 30; p_br = 12; p_fl = 4;
        for (int k = 0; k < 4000; k++) begin
            if (dead) break;
            cycle();
        end

`ifdef FETCH_TIMEOUT_EN
        do_reset();
        n8 = 0; seen = 1'b0; done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            stall         = '0;
            flush         = 1'b0;
            branch_flag_i = 1'b0;
            imem.inst_ack_i   = imem.inst_req_o &&
                                (imem.inst_addr_o != 32'h8);
            imem.inst_rdata_i = memf(imem.inst_addr_o);
            #1;
            if (seen && imem.inst_req_o) begin
                check("tmo_next", imem.inst_addr_o, 32'hC);
                done = 1'b1;
            end else if (imem.inst_req_o && imem.inst_addr_o == 32'h8) begin
                n8++;
                if (n8 == 8) begin
                    check("tmo_err", 32'(if_fetch_err_o), 1);
                    check("tmo_pc", if_pc, 32'h8);
                    check("tmo_inst", if_inst, 0);
                    check("tmo_sreq", 32'(stallreq_if), 0);
                    seen = 1'b1;
                end else begin
                    check("tmo_quiet", 32'(if_fetch_err_o), 0);
                end
            end
        end
        check("tmo_done", 32'(done), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
